// File: rtl/lsu_master.sv
// Load/store unit: turns one RV32I load/store into word-aligned memory reads/writes,
// with read-modify-write for SB/SH. Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W.
module lsu_master #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic        mem_MemRW,
  input  logic [31:0] mem_dataB
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  logic [1:0]  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] old_q, old_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        f3_bad, range_bad, align_bad, req_bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data, merged;

  assign accept = req_valid && (state_q == S_IDLE);

  assign f3_bad    = req_we ? (req_funct3 != 3'b000 && req_funct3 != 3'b001 && req_funct3 != 3'b010)
                            : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
  assign range_bad = {2'b00, req_addr[31:2]} >= MEM_WORDS_L;
`ifdef LSU_MISALIGN_TRAP_EN
  assign align_bad = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign align_bad = 1'b0;
`endif
  assign req_bad = f3_bad || range_bad || align_bad;

  // Lane extraction from the word currently on the read bus
  assign lane_b = mem_dataB[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_dataB[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'b0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'b0, lane_h};
      default: load_data = mem_dataB;
    endcase
  end

  always_comb begin
    merged = old_q;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    old_d       = old_q;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d   = S_RSP;
            rsp_err_d = 1'b1;
          end else if (req_we && req_funct3 == 3'b010) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          old_d   = mem_dataB;
          state_d = S_WR;
        end else begin
          rsp_rdata_d = load_data;
          state_d     = S_RSP;
        end
      end
      S_WR:    state_d = S_RSP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      old_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      old_q       <= old_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Memory strobes decode straight from state so reset drops a pending write at once
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = (state_q == S_RD || state_q == S_WR) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_dataW = (state_q == S_WR) ? merged : 32'h0;
  assign mem_MemRW = (state_q == S_WR);

endmodule

// File: tb/tb_lsu_master.sv
// Scoreboard bench for lsu_master: stimulus pushes expected responses and direct
// checks into queues; a negedge monitor pops and compares them.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataW;
  logic        mem_MemRW;
  logic [31:0] mem_dataB;

  always #5 clk = ~clk;

  lsu_master #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_MemRW(mem_MemRW),
    .mem_dataB(mem_dataB)
  );

  // Data memory stand-in with a backdoor write port for preloading
  logic [31:0] mem [0:31];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_idx = 5'd0;
  logic [31:0] bd_data = 32'h0;

  assign mem_dataB = (mem_addr[31:7] == 25'h0) ? mem[mem_addr[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (mem_MemRW && mem_addr[31:7] == 25'h0) mem[mem_addr[6:2]] <= mem_dataW;
  end

  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] wr_addr_last = 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (mem_MemRW) begin
        wr_cnt       <= wr_cnt + 1;
        wr_addr_last <= mem_addr;
      end else if (mem_addr != 32'h0) begin
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  exp_t  sb_q[$];
  dchk_t dq[$];
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    exp_t  e;
    dchk_t d;
    while (dq.size() != 0) begin
      d = dq.pop_front();
      checks++;
      if (d.act !== d.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", d.name, d.act, d.exp);
      end
    end
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got err=%b rdata=%h at cycle %0d, expected no response",
                 rsp_err, rsp_rdata, cyc);
      end else begin
        e = sb_q.pop_front();
        if (rsp_err !== e.err || rsp_rdata !== e.rdata || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got err=%b rdata=%h cycle=%0d, expected err=%b rdata=%h cycle=%0d",
                   e.name, rsp_err, rsp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
      end
    end else if (rst_n === 1'b1) begin
      checks++;
      if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL idle_rsp_zero: got err=%b rdata=%h, expected 0 and 0", rsp_err, rsp_rdata);
      end
    end
  end

  task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    dq.push_back('{n, a, e});
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx[4:0];
    bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Leaves req_valid high at the negedge before the accepting edge
  task automatic start_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit push, input logic err,
                           input logic [31:0] rdata, input int lat, input string name);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) push_chk({name, "_ready_timeout"}, {31'h0, req_ready}, 32'h1);
    if (push) sb_q.push_back('{name, err, rdata, cyc + lat});
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      push_chk({name, "_rsp_timeout"}, 32'(sb_q.size()), 32'h0);
      sb_q.delete();
    end
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input int lat, input string name);
    start_req(we, f3, addr, wdata, 1'b1, err, rdata, lat, name);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    wait_rsp(name);
  endtask

  int w0, r0;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    push_chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    push_chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    push_chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    push_chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    push_chk("rst_mem_addr", mem_addr, 32'h0);
    push_chk("rst_mem_dataW", mem_dataW, 32'h0);
    push_chk("rst_mem_MemRW", {31'h0, mem_MemRW}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    poke(0, 32'h0);
    poke(10, 32'h0);
    poke(11, 32'h0);
    poke(31, 32'h1234_5678);

    // Word store
    w0 = wr_cnt; r0 = rd_cnt;
    do_op(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, "sw_10");
    push_chk("sw_wr_cycles", 32'(wr_cnt - w0), 32'h1);
    push_chk("sw_rd_cycles", 32'(rd_cnt - r0), 32'h0);
    push_chk("sw_wr_addr", wr_addr_last, 32'h10);
    push_chk("sw_mem4", mem[4], 32'hDEAD_BEEF);

    // Loads with sign/zero extension
    poke(4, 32'h80F1_7F01);
    do_op(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF80, 2, "lb_13");
    do_op(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h0000_0080, 2, "lbu_13");
    do_op(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'h0000_7F01, 2, "lh_10");
    do_op(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_80F1, 2, "lhu_12");
    do_op(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF_80F1, 2, "lh_12");
    do_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h80F1_7F01, 2, "lw_10");
    do_op(1'b0, 3'b010, 32'h7C, 32'h0, 1'b0, 32'h1234_5678, 2, "lw_last_word");

    // Sub-word read-modify-write stores
    poke(8, 32'h1122_3344);
    w0 = wr_cnt; r0 = rd_cnt;
    do_op(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 1'b0, 32'h0, 3, "sb_21");
    push_chk("sb_rd_cycles", 32'(rd_cnt - r0), 32'h1);
    push_chk("sb_wr_cycles", 32'(wr_cnt - w0), 32'h1);
    push_chk("sb_mem8", mem[8], 32'h1122_AB44);
    do_op(1'b1, 3'b001, 32'h22, 32'h0000_CDEF, 1'b0, 32'h0, 3, "sh_22");
    push_chk("sh_mem8", mem[8], 32'hCDEF_AB44);

    // Rejected requests
    w0 = wr_cnt;
    do_op(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, "st_f3_011");
    do_op(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, "st_f3_100");
    do_op(1'b1, 3'b010, 32'h80, 32'hFFFF_FFFF, 1'b1, 32'h0, 1, "sw_80_range");
    push_chk("err_no_write", 32'(wr_cnt - w0), 32'h0);
    push_chk("err_mem4", mem[4], 32'h80F1_7F01);
    do_op(1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 32'h0, 1, "lw_80_range");
    do_op(1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 1, "ld_f3_110");

`ifdef LSU_MISALIGN_TRAP_EN
    do_op(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1, "lw_12_misalign");
    do_op(1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0, 1, "lh_11_misalign");
`else
    do_op(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, 32'h80F1_7F01, 2, "lw_12_misalign");
    do_op(1'b0, 3'b001, 32'h11, 32'h0, 1'b0, 32'h0000_7F01, 2, "lh_11_misalign");
`endif

    // req_valid held high with changing requests while busy
    poke(9, 32'h0102_0304);
    w0 = wr_cnt;
    start_req(1'b1, 3'b000, 32'h27, 32'h0000_0099, 1'b1, 1'b0, 32'h0, 3, "sb_busy");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h28 + 32'(4 * (i % 2));
      req_wdata  = 32'hFFFF_FFFF;
    end
    req_valid = 1'b0;
    #1;
    wait_rsp("sb_busy");
    push_chk("busy_mem9", mem[9], 32'h9902_0304);
    push_chk("busy_mem10", mem[10], 32'h0);
    push_chk("busy_mem11", mem[11], 32'h0);
    push_chk("busy_wr_cycles", 32'(wr_cnt - w0), 32'h1);

    // Reset during the SB write cycle
    poke(12, 32'hA5A5_A5A5);
    w0 = wr_cnt;
    start_req(1'b1, 3'b000, 32'h31, 32'h0000_005A, 1'b0, 1'b0, 32'h0, 3, "sb_rst");
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    push_chk("rst_in_wr", {31'h0, mem_MemRW}, 32'h1);
    rst_n = 1'b0;
    #1;
    push_chk("rst_wr_MemRW", {31'h0, mem_MemRW}, 32'h0);
    push_chk("rst_wr_ready", {31'h0, req_ready}, 32'h1);
    push_chk("rst_wr_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    push_chk("rst_wr_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    push_chk("rst_mem12", mem[12], 32'hA5A5_A5A5);
    push_chk("rst_no_write", 32'(wr_cnt - w0), 32'h0);
    do_op(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hA5A5_A5A5, 2, "lw_30_after_rst");

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
